// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider controller.
package clk_div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PEND, STOP} state_e;

  localparam int unsigned MIN_DIV = 2;

  // Number of high cycles in one output period of divisor n.
  function automatic int unsigned half_hi(input int unsigned n);
    return (n + 1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter for the divider: wrap detect, registered clk_out/tick and the divisor load strobe.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             active,
  input  logic             run,
  input  logic             pend_vld,
  input  logic [DIV_W-1:0] div_n,
  output logic             wrap,
  output logic             load,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  always_comb begin
    wrap = active && (cnt_q == (div_n - ONE));
    load = wrap && pend_vld;
    // A fresh start and a wrap both restart the period at zero.
    if (!run || !active || wrap) cnt_d = '0;
    else                         cnt_d = cnt_q + ONE;
    clk_out_d = run && (32'(cnt_d) < half_hi(32'(div_n)));
    tick_d    = run && (cnt_d == '0);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable divider controller: FSM, config handshake, pending divisor and error pulse.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 3
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [DIV_W-1:0] cur_div
);

  localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] MIN_N = DIV_W'(MIN_DIV);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_vld_q, pend_vld_d;
  logic             cfg_err_q, cfg_err_d;
  logic             busy_q, busy_d;
  logic             acc, acc_ok, wrap, load;

  assign cfg_ready = (state_q != PEND);

  always_comb begin
    acc        = cfg_valid && cfg_ready;
    acc_ok     = acc && (cfg_div >= MIN_N);
    cfg_err_d  = acc && !acc_ok;
    state_d    = state_q;
    cur_div_d  = load ? pend_div_q : cur_div_q;
    pend_div_d = pend_div_q;
    pend_vld_d = load ? 1'b0 : pend_vld_q;

    // While idle a divisor takes effect at once; otherwise it waits for a wrap.
    if (acc_ok) begin
      if (state_q == IDLE) begin
        cur_div_d = cfg_div;
      end else begin
        pend_div_d = cfg_div;
        pend_vld_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: if (enable) state_d = RUN;
      RUN: begin
        if (acc_ok)       state_d = PEND;
        else if (!enable) state_d = STOP;
      end
      PEND: if (wrap) state_d = enable ? RUN : STOP;
      STOP: begin
        if (enable) begin
          state_d = pend_vld_d ? PEND : RUN;
        end else if (wrap) begin
          state_d = IDLE;
          // A divisor offered on the final wrap must not be lost when going idle.
          if (acc_ok) begin
            cur_div_d  = cfg_div;
            pend_vld_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_div_q  <= DEF_N;
      pend_div_q <= '0;
      pend_vld_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
      cfg_err_q  <= cfg_err_d;
      busy_q     <= busy_d;
    end
  end

  clk_div_core #(.DIV_W(DIV_W)) u_core (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .active   (state_q != IDLE),
    .run      (state_d != IDLE),
    .pend_vld (pend_vld_q),
    .div_n    (cur_div_q),
    .wrap     (wrap),
    .load     (load),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  assign cfg_err = cfg_err_q;
  assign busy    = busy_q;
  assign cur_div = cur_div_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: a cycle table of inputs/expected outputs plus a mid-period reset sequence.
module tb_clk_div_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready, cfg_err, clk_out, tick, busy;
  logic [7:0] cur_div;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    logic       v;
    logic [7:0] d;
    logic       clk;
    logic       tck;
    logic       bsy;
    logic       rdy;
    logic       err;
    logic [7:0] cur;
  } vec_t;

  vec_t vq[$];

  clk_div_ctrl #(.DIV_W(8), .DEF_DIV(3)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy),
    .cur_div   (cur_div)
  );

  always #10 clk_in = ~clk_in;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic v, input logic [7:0] d,
                     input logic c, input logic t, input logic b, input logic r,
                     input logic e, input logic [7:0] cur);
    vec_t x;
    x.en = en; x.v = v; x.d = d; x.clk = c; x.tck = t;
    x.bsy = b; x.rdy = r; x.err = e; x.cur = cur;
    vq.push_back(x);
  endtask

  task automatic step(input logic en, input logic v, input logic [7:0] d);
    enable = en; cfg_valid = v; cfg_div = d;
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_all(input int idx, input vec_t x);
    chk("clk_out",   idx, 32'(clk_out),   32'(x.clk));
    chk("tick",      idx, 32'(tick),      32'(x.tck));
    chk("busy",      idx, 32'(busy),      32'(x.bsy));
    chk("cfg_ready", idx, 32'(cfg_ready), 32'(x.rdy));
    chk("cfg_err",   idx, 32'(cfg_err),   32'(x.err));
    chk("cur_div",   idx, 32'(cur_div),   32'(x.cur));
  endtask

  initial begin
    logic [5:0] exp_clk;
    logic [5:0] exp_tck;
    exp_clk = 6'b110110;
    exp_tck = 6'b100100;

    // en v d | clk tick busy rdy err cur
    // N=3 start: 110 repeating
    add(1,0,0, 1,1,1,1,0,3); add(1,0,0, 1,0,1,1,0,3); add(1,0,0, 0,0,1,1,0,3);
    add(1,0,0, 1,1,1,1,0,3); add(1,0,0, 1,0,1,1,0,3);
    // offer 4 mid-period: ready drops one cycle, 1100 after the wrap
    add(1,1,4, 0,0,1,0,0,3); add(1,0,0, 1,1,1,1,0,4); add(1,0,0, 1,0,1,1,0,4);
    add(1,0,0, 0,0,1,1,0,4); add(1,0,0, 0,0,1,1,0,4); add(1,0,0, 1,1,1,1,0,4);
    // divisors 1 and 0 rejected
    add(1,1,1, 1,0,1,1,1,4); add(1,0,0, 0,0,1,1,0,4); add(1,1,0, 0,0,1,1,1,4);
    add(1,0,0, 1,1,1,1,0,4);
    // stop at N=4, then load 5 while idle
    add(0,0,0, 1,0,1,1,0,4); add(0,0,0, 0,0,1,1,0,4); add(0,0,0, 0,0,1,1,0,4);
    add(0,0,0, 0,0,0,1,0,4); add(0,1,5, 0,0,0,1,0,5);
    // N=5, drop enable at cnt=1: 11100 then low
    add(1,0,0, 1,1,1,1,0,5); add(1,0,0, 1,0,1,1,0,5); add(0,0,0, 1,0,1,1,0,5);
    add(0,0,0, 0,0,1,1,0,5); add(0,0,0, 0,0,1,1,0,5); add(0,0,0, 0,0,0,1,0,5);
    add(0,0,0, 0,0,0,1,0,5); add(1,0,0, 1,1,1,1,0,5);
    // back to N=3
    add(1,1,3, 1,0,1,0,0,5); add(1,0,0, 1,0,1,0,0,5); add(1,0,0, 0,0,1,0,0,5);
    add(1,0,0, 0,0,1,0,0,5); add(1,0,0, 1,1,1,1,0,3); add(1,0,0, 1,0,1,1,0,3);
    add(1,0,0, 0,0,1,1,0,3);
    // offer 6 exactly at cnt==N-1: one more N=3 period, then 111000
    add(1,1,6, 1,1,1,0,0,3); add(1,0,0, 1,0,1,0,0,3); add(1,0,0, 0,0,1,0,0,3);
    add(1,0,0, 1,1,1,1,0,6); add(1,0,0, 1,0,1,1,0,6); add(1,0,0, 1,0,1,1,0,6);
    add(1,0,0, 0,0,1,1,0,6); add(1,0,0, 0,0,1,1,0,6); add(1,0,0, 0,0,1,1,0,6);
    add(1,0,0, 1,1,1,1,0,6);
    // enable=0 together with cfg 2: applied at wrap, then one N=2 period, then idle
    add(0,1,2, 1,0,1,0,0,6); add(0,0,0, 1,0,1,0,0,6); add(0,0,0, 0,0,1,0,0,6);
    add(0,0,0, 0,0,1,0,0,6); add(0,0,0, 0,0,1,0,0,6); add(0,0,0, 1,1,1,1,0,2);
    add(0,0,0, 0,0,1,1,0,2); add(0,0,0, 0,0,0,1,0,2);

    rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_clk_out", 0, 32'(clk_out),   32'd0);
    chk("rst_tick",    0, 32'(tick),      32'd0);
    chk("rst_busy",    0, 32'(busy),      32'd0);
    chk("rst_err",     0, 32'(cfg_err),   32'd0);
    chk("rst_ready",   0, 32'(cfg_ready), 32'd1);
    chk("rst_cur_div", 0, 32'(cur_div),   32'd3);
    @(negedge clk_in);
    rst_n = 1'b1;
    @(posedge clk_in);
    #1;

    foreach (vq[i]) begin
      step(vq[i].en, vq[i].v, vq[i].d);
      chk_all(i + 1, vq[i]);
    end

    // N=4 running, then asynchronous reset mid-period
    step(0, 1, 4);
    chk("load4_cur_div", 100, 32'(cur_div), 32'd4);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("pre_rst_clk_out", 101, 32'(clk_out), 32'd1);
    #5;
    rst_n = 1'b0;
    #1;
    chk("async_clk_out", 102, 32'(clk_out), 32'd0);
    chk("async_cur_div", 102, 32'(cur_div), 32'd3);
    chk("async_busy",    102, 32'(busy),    32'd0);
    chk("async_tick",    102, 32'(tick),    32'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 0);
      chk("restart_clk_out", 110 + k, 32'(clk_out), 32'(exp_clk[5-k]));
      chk("restart_tick",    110 + k, 32'(tick),    32'(exp_tck[5-k]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
